// File: rtl/brc_pkg.sv
// Shared encodings and default parameters for the bit-clock recovery core.
package brc_pkg;

    typedef enum logic {
        MODE_HALF = 1'b0,   // clk_rec toggles every period/2
        MODE_FULL = 1'b1    // clk_rec toggles every period
    } brc_mode_e;

    localparam int unsigned BRC_CW           = 16;
    localparam int unsigned BRC_INIT_PERIOD  = 801;
    localparam int unsigned BRC_MIN_PERIOD   = 4;
    localparam int unsigned BRC_STABLE_EDGES = 16;
    localparam int unsigned BRC_LOCK_EDGES   = 32;
    localparam int unsigned BRC_ALIGN_SHIFT  = 3;

endpackage

// File: rtl/brc_edge_sync.sv
// Two-flop synchroniser for the asynchronous serial input plus transition detect.
module brc_edge_sync
    import brc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic signal_in,
    output logic sync2,
    output logic edge_pulse
);

    logic sync1;
    logic prev;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_pulse = sync2 ^ prev;

endmodule

// File: rtl/bit_clock_recovery_core.sv
// Tracks the shortest edge-to-edge interval as the bit period and regenerates
// a phase-realigned clock, lock flag and mid-bit sample strobe from it.
module bit_clock_recovery_core
    import brc_pkg::*;
#(
    parameter int unsigned CW           = BRC_CW,
    parameter int unsigned INIT_PERIOD  = BRC_INIT_PERIOD,
    parameter int unsigned MIN_PERIOD   = BRC_MIN_PERIOD,
    parameter int unsigned STABLE_EDGES = BRC_STABLE_EDGES,
    parameter int unsigned LOCK_EDGES   = BRC_LOCK_EDGES,
    parameter int unsigned ALIGN_SHIFT  = BRC_ALIGN_SHIFT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          signal_in,
    input  logic          mode,
    input  logic          invert_req,
    output logic          clk_rec,
    output logic [CW-1:0] period_out,
    output logic          locked,
    output logic          sample_valid,
    output logic          sample_data
);

    localparam int unsigned SW = $clog2(STABLE_EDGES + 1);
    localparam int unsigned LW = $clog2(LOCK_EDGES + 1);

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] MIN_P      = CW'(MIN_PERIOD);
    localparam logic [CW-1:0] INIT_P     = CW'(INIT_PERIOD);
    localparam logic [SW-1:0] STABLE_TOP = SW'(STABLE_EDGES - 1);
    localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_EDGES);

    logic          sync2;
    logic          data_edge;
    logic [CW-1:0] interval_cnt;
    logic [CW-1:0] period_q;
    logic [CW-1:0] phase_cnt;
    logic [SW-1:0] stable_cnt;
    logic [LW-1:0] lock_cnt;
    logic          clk_rec_d;

    logic          edge_ok;
    logic          shrink;
    logic          interval_sat;
    logic [CW-1:0] thr;
    logic [CW-1:0] align_win;
    logic          toggle;
    logic          realign;
    logic          clk_rec_rise;

    brc_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal_in  (signal_in),
        .sync2      (sync2),
        .edge_pulse (data_edge)
    );

    // NOTE: every always_comb output is assigned on every path so no latch can be inferred.
    always_comb begin
        edge_ok      = data_edge && (interval_cnt >= MIN_P);
        shrink       = edge_ok && (interval_cnt < period_q);
        interval_sat = (interval_cnt == CNT_MAX);
        thr          = (brc_mode_e'(mode) == MODE_FULL) ? period_q : (period_q >> 1);
        align_win    = period_q >> ALIGN_SHIFT;
        toggle       = (phase_cnt >= thr);
        realign      = !toggle && edge_ok && (phase_cnt < align_win);
        clk_rec_rise = clk_rec && !clk_rec_d;
    end

    // Period tracking: shrink instantly, creep up by one after a run of stable edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_cnt <= '0;
            period_q     <= INIT_P;
            stable_cnt   <= '0;
            lock_cnt     <= '0;
            locked       <= 1'b0;
        end else begin
            if (edge_ok) begin
                interval_cnt <= CNT_ONE;
            end else if (!interval_sat) begin
                interval_cnt <= interval_cnt + CNT_ONE;
            end

            if (shrink) begin
                period_q   <= interval_cnt;
                stable_cnt <= '0;
            end else if (edge_ok) begin
                if (stable_cnt == STABLE_TOP) begin
                    if (period_q != CNT_MAX) begin
                        period_q <= period_q + CNT_ONE;
                    end
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + SW'(1);
                end
            end

            // A saturated interval means the signal has gone quiet: drop lock.
            if (interval_sat || shrink) begin
                lock_cnt <= '0;
            end else if (edge_ok && (lock_cnt != LOCK_TOP)) begin
                lock_cnt <= lock_cnt + LW'(1);
            end

            locked <= (lock_cnt == LOCK_TOP);
        end
    end

    // Recovered clock: threshold toggle wins over realignment; invert_req XORs in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt    <= '0;
            clk_rec      <= 1'b0;
            clk_rec_d    <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= 1'b0;
        end else begin
            if (toggle || realign) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + CNT_ONE;
            end

            clk_rec      <= clk_rec ^ toggle ^ invert_req;
            clk_rec_d    <= clk_rec;
            sample_valid <= clk_rec_rise;
            if (clk_rec_rise) begin
                sample_data <= sync2;
            end
        end
    end

    assign period_out = period_q;

endmodule

// File: tb/tb_bit_clock_recovery_core.sv
// Directed bench for bit_clock_recovery_core: period tracking, lock, glitch
// rejection, realignment window, mode/invert handling, loss of signal and reset.
module tb_bit_clock_recovery_core;
    import brc_pkg::*;

    // Narrow counters so the loss-of-signal case (2^CW idle cycles) stays short.
    localparam int TB_CW = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             signal_in;
    logic             mode;
    logic             invert_req;
    logic             clk_rec;
    logic [TB_CW-1:0] period_out;
    logic             locked;
    logic             sample_valid;
    logic             sample_data;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    bit_clock_recovery_core #(.CW(TB_CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_in    (signal_in),
        .mode         (mode),
        .invert_req   (invert_req),
        .clk_rec      (clk_rec),
        .period_out   (period_out),
        .locked       (locked),
        .sample_valid (sample_valid),
        .sample_data  (sample_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Counts negedges until clk_rec changes (limit+1 if it never does). On
    // negedge i it may pulse invert_req, switch mode or toggle signal_in.
    task automatic measure(input int limit, input int inv_at, input int mode_at,
                           input logic mode_val, input int sig_at, output int cycles);
        logic start;
        start  = clk_rec;
        cycles = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            invert_req = (i == inv_at);
            if (i == mode_at) mode = mode_val;
            if (i == sig_at) signal_in = ~signal_in;
            if (clk_rec !== start) begin
                cycles = i;
                break;
            end
        end
        invert_req = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        signal_in  = 1'b0;
        mode       = MODE_HALF;
        invert_req = 1'b0;

        // 1: reset values, then free-running clk_rec at INIT_PERIOD in half mode.
        // thr = 801>>1 = 400 and phase runs 0..400, so each half-cycle is 401 clocks.
        wait_cycles(3);
        check("rst_clk_rec", clk_rec, 0);
        check("rst_period", period_out, 801);
        check("rst_locked", locked, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_data", sample_data, 0);
        rst_n = 1'b1;
        measure(1000, 0, 0, 1'b0, 0, n);
        check("t1_first_toggle", n, 401);
        measure(1000, 0, 0, 1'b0, 0, n);
        check("t1_toggle_fall", n, 401);
        measure(1000, 0, 0, 1'b0, 0, n);
        check("t1_toggle_rise", n, 401);
        check("t1_clk_rec_high", clk_rec, 1);
        check("t1_sv_not_yet", sample_valid, 0);
        @(negedge clk);
        check("t1_sv_pulse", sample_valid, 1);
        check("t1_sd_zero", sample_data, 0);
        @(negedge clk);
        check("t1_sv_one_cycle", sample_valid, 0);
        check("t1_locked_idle", locked, 0);

        // 2: 100-cycle stream, nudge to 101 after 16 edges, shrink back; then a
        // 98 -> 99 -> 100 drift that gives 32 non-shrinking edges for lock.
        signal_in = ~signal_in;                                   // E1
        wait_cycles(100); signal_in = ~signal_in;                 // E2
        wait_cycles(100);
        check("t2_period_e2", period_out, 100);
        signal_in = ~signal_in;                                   // E3
        for (int e = 4; e <= 17; e++) begin
            wait_cycles(100); signal_in = ~signal_in;
        end
        wait_cycles(100);
        check("t2_before_nudge", period_out, 100);
        signal_in = ~signal_in;                                   // E18
        wait_cycles(100);
        check("t2_nudged", period_out, 101);
        signal_in = ~signal_in;                                   // E19
        wait_cycles(98);
        check("t2_shrink_back", period_out, 100);
        check("t2_not_locked", locked, 0);
        signal_in = ~signal_in;                                   // E20
        wait_cycles(98);
        check("t2_period_98", period_out, 98);
        signal_in = ~signal_in;                                   // E21
        for (int e = 22; e <= 36; e++) begin
            wait_cycles(98); signal_in = ~signal_in;
        end
        wait_cycles(99);
        check("t2_period_99", period_out, 99);
        signal_in = ~signal_in;                                   // E37
        for (int e = 38; e <= 51; e++) begin
            wait_cycles(99); signal_in = ~signal_in;
        end
        wait_cycles(99);
        check("t2_lock_31_edges", locked, 0);
        signal_in = ~signal_in;                                   // E52
        wait_cycles(100);
        check("t2_locked", locked, 1);
        check("t2_period_100", period_out, 100);

        // 3: 2-cycle pulse right after a real edge; both pulse edges have m < 4.
        signal_in = ~signal_in;                                   // E53
        wait_cycles(1); signal_in = ~signal_in;
        wait_cycles(2); signal_in = ~signal_in;
        wait_cycles(97);
        check("t3_glitch_period", period_out, 100);
        check("t3_glitch_locked", locked, 1);
        signal_in = ~signal_in;                                   // E54
        wait_cycles(10);
        check("t3_after_period", period_out, 100);
        check("t3_after_locked", locked, 1);

        // 4: window = 100>>3 = 12. Toggling signal_in at negedge w lands the
        // accepted edge where phase_cnt = w+2; half-cycle is 51 clocks.
        wait_cycles(100);
        measure(200, 0, 0, 1'b0, 0, n);
        measure(200, 0, 0, 1'b0, 9, n);
        check("t4_realign_phase11", n, 63);
        measure(200, 0, 0, 1'b0, 0, n);
        check("t4_spacing_after", n, 51);
        measure(200, 0, 0, 1'b0, 10, n);
        check("t4_no_realign_phase12", n, 51);
        check("t4_period", period_out, 100);
        check("t4_locked", locked, 1);

        // 5: full mode (101-clock half-cycles), invert cancelling a toggle,
        // isolated invert, then an immediate toggle on switching back to half.
        mode = MODE_FULL;
        measure(300, 0, 0, 1'b0, 0, n);
        check("t5_full_first", n, 101);
        measure(300, 0, 0, 1'b0, 0, n);
        check("t5_full_spacing", n, 101);
        measure(300, 100, 0, 1'b0, 0, n);
        check("t5_invert_cancel", n, 202);
        measure(300, 30, 0, 1'b0, 0, n);
        check("t5_invert_isolated", n, 31);
        measure(300, 0, 0, 1'b0, 0, n);
        check("t5_after_invert", n, 70);
        measure(300, 0, 70, MODE_HALF, 0, n);
        check("t5_mode_switch_now", n, 71);
        measure(300, 0, 0, 1'b0, 0, n);
        check("t5_half_again", n, 51);

        // 6: silence until interval saturates (4095), then data capture and reset.
        wait_cycles(3000);
        check("t6_still_locked", locked, 1);
        wait_cycles(1000);
        check("t6_lost_lock", locked, 0);
        check("t6_period_kept", period_out, 100);
        signal_in = 1'b1;
        wait_cycles(5);
        measure(200, 0, 0, 1'b0, 0, n);
        if (clk_rec !== 1'b1) measure(200, 0, 0, 1'b0, 0, n);
        check("t6_rise_seen", clk_rec, 1);
        @(negedge clk);
        check("t6_sv_pulse", sample_valid, 1);
        check("t6_sd_one", sample_data, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_clk_rec", clk_rec, 0);
        check("t6_rst_period", period_out, 801);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_sv", sample_valid, 0);
        check("t6_rst_sd", sample_data, 0);

        // First edge after reset: the synchroniser's 0->1 seen at m=2 is rejected,
        // the driven edge lands with interval_cnt = 52.
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(50);
        signal_in = ~signal_in;
        wait_cycles(10);
        check("t6_first_edge_from_reset", period_out, 52);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
